pulse_measure: RTL and testbench
================================

PULSE_MEASURE -- requirements
Module: pulse_measure

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of the time and width counters (legal 8..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, depth of the PULSE input synchronizer (legal 2..4).
REQ-003 SHALL provide parameter PULSE_TYPE, default 1: 1 = active-high pulse, 0 = active-low pulse.
REQ-004 SHALL provide port CLK  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL provide port RESETN  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL provide port PULSE  input  1  asynchronous pulse under measurement.
REQ-007 SHALL provide port ARM  input  1  single-cycle request that starts a measurement; time zero.
REQ-008 SHALL provide port ACK  input  1  consumer acknowledge of the result.
REQ-009 SHALL provide port START_TIME  output  CNT_W  cycles from ARM acceptance to the detected leading edge.
REQ-010 SHALL provide port WIDTH  output  CNT_W  cycles between the detected leading and trailing edges.
REQ-011 SHALL provide port VALID  output  1  result held and stable.
REQ-012 SHALL provide port BUSY  output  1  measurement in progress (state WAIT_EDGE or IN_PULSE).
REQ-013 SHALL provide port OVERFLOW  output  1  result aborted on counter saturation.

Function
REQ-014 SHALL pass PULSE through SYNC_STAGES flops, then invert it when PULSE_TYPE=0, giving internal signal "act".
REQ-015 SHALL define leading edge as act 0->1 and trailing edge as act 1->0, using one registered copy of act.
REQ-016 SHALL implement FSM states IDLE, WAIT_EDGE, IN_PULSE, DONE; reset state IDLE.
REQ-017 IDLE: ARM=1 clears time counter to 0 and enters WAIT_EDGE; ARM in any other state SHALL be ignored.
REQ-018 WAIT_EDGE: time counter increments each cycle; on leading edge, capture counter into START_TIME, load width counter with 1, enter IN_PULSE.
REQ-019 Pulse already active when ARM is accepted SHALL NOT count as a leading edge; the FSM waits for a fresh 0->1.
REQ-020 IN_PULSE: width counter increments each cycle; on trailing edge, capture width counter into WIDTH, assert VALID, enter DONE.
REQ-021 For a clean input held active for N CLK edges, WIDTH SHALL equal N; START_TIME SHALL equal D+SYNC_STAGES, D = CLK edges from ARM sample to first edge sampling PULSE active.
REQ-022 Either counter reaching all-ones SHALL saturate, set OVERFLOW=1, assert VALID and enter DONE; the uncaptured field reads all-ones.
REQ-023 DONE: START_TIME, WIDTH, VALID, OVERFLOW held until ACK=1, then VALID and OVERFLOW clear next cycle and FSM enters IDLE.
REQ-024 ACK outside DONE SHALL have no effect; ARM and ACK in the same DONE cycle: ACK honoured, ARM dropped.
REQ-025 Leading and trailing edges cannot both occur in one cycle; a one-cycle synchronized pulse SHALL yield WIDTH=1.

Reset
REQ-026 RESETN=0 SHALL asynchronously force IDLE, synchronizer flops to inactive level, counters, START_TIME and WIDTH to 0, and VALID, BUSY, OVERFLOW to 0.
REQ-027 Reset mid-measurement SHALL discard the measurement; no VALID after release until a new ARM completes.
REQ-028 Reset deassertion SHALL be used synchronized externally; the block imposes no extra release latency.

Configuration
REQ-029 Macro PULSE_MEASURE_GLITCH_FILTER_EN defined: act SHALL change only after the synchronized input holds a new level for 3 consecutive cycles; both edges delayed 2 cycles, so WIDTH unchanged and START_TIME +2; pulses shorter than 3 cycles ignored.
REQ-030 Macro undefined: act SHALL be the synchronized input directly, with no filtering and no added latency.

Verification
REQ-031 Defaults, ARM at t0, PULSE high 500 cycles after ARM for 500 cycles -> VALID=1, START_TIME=502, WIDTH=500, OVERFLOW=0.
REQ-032 PULSE_TYPE=0, PULSE low 10 cycles starting 20 cycles after ARM -> START_TIME=22, WIDTH=10.
REQ-033 PULSE already high at ARM, falls at +5, rises at +30 for 7 cycles -> START_TIME=32, WIDTH=7.
REQ-034 CNT_W=8, no pulse after ARM -> after 255 cycles OVERFLOW=1, VALID=1, START_TIME=255; ACK clears both next cycle.
REQ-035 RESETN low for 1 cycle during IN_PULSE -> all outputs 0 immediately; a following ARM gives a correct fresh result.
REQ-036 With PULSE_MEASURE_GLITCH_FILTER_EN, 2-cycle glitch then 500-cycle pulse at +500 -> glitch ignored, START_TIME=504, WIDTH=500.

Source files
------------

// File: rtl/pulse_measure.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_measure: measures ARM-to-leading-edge delay and width of a pulse.  |
// | Optional glitch filter: define PULSE_MEASURE_GLITCH_FILTER_EN. Rev 1.0   |
// +--------------------------------------------------------------------------+
module pulse_measure #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_TYPE  = 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             PULSE,
  input  logic             ARM,
  input  logic             ACK,
  output logic [CNT_W-1:0] START_TIME,
  output logic [CNT_W-1:0] WIDTH,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVERFLOW
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = (PULSE_TYPE != 0) ? '0 : '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   act;
  logic                   act_q;
  logic                   lead;
  logic                   trail;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [CNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [CNT_W-1:0] start_q, start_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             ovf_q, ovf_d;

  // Synchronizer resets to the inactive raw level so no false edge on release.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) sync_q <= SYNC_RST;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], PULSE};
  end

  assign sync_lvl = (PULSE_TYPE != 0) ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];

`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       stable;

  // Current sample plus two history samples agreeing means 3 cycles at one level.
  assign stable = (sync_lvl == hist_q[0]) && (hist_q[0] == hist_q[1]);
  assign act    = stable ? sync_lvl : filt_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_lvl};
      filt_q <= act;
    end
  end
`else
  assign act = sync_lvl;
`endif

  assign lead     = act & ~act_q;
  assign trail    = ~act & act_q;
  assign tcnt_inc = tcnt_q + CNT_W'(1);
  assign wcnt_inc = wcnt_q + CNT_W'(1);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ARM) state_d = S_WAIT;
      S_WAIT:  if (lead) state_d = S_PULSE;
               else if (tcnt_inc == CNT_MAX) state_d = S_DONE;
      S_PULSE: if (trail || (wcnt_inc == CNT_MAX)) state_d = S_DONE;
      S_DONE:  if (ACK) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    VALID      = (state_q == S_DONE);
    BUSY       = (state_q == S_WAIT) || (state_q == S_PULSE);
    OVERFLOW   = ovf_q;
    START_TIME = start_q;
    WIDTH      = width_q;
  end

  // The time counter reads D+SYNC_STAGES-1 when the edge is seen, so capture its increment.
  always_comb begin
    tcnt_d  = tcnt_q;
    wcnt_d  = wcnt_q;
    start_d = start_q;
    width_d = width_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: if (ARM) tcnt_d = '0;
      S_WAIT: begin
        tcnt_d = tcnt_inc;
        if (lead) begin
          start_d = tcnt_inc;
          wcnt_d  = CNT_W'(1);
        end else if (tcnt_inc == CNT_MAX) begin
          start_d = CNT_MAX;
          width_d = CNT_MAX;
          ovf_d   = 1'b1;
        end
      end
      S_PULSE: begin
        wcnt_d = wcnt_inc;
        if (trail) begin
          width_d = wcnt_q;
        end else if (wcnt_inc == CNT_MAX) begin
          width_d = CNT_MAX;
          ovf_d   = 1'b1;
        end
      end
      S_DONE: if (ACK) ovf_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      act_q   <= 1'b0;
      tcnt_q  <= '0;
      wcnt_q  <= '0;
      start_q <= '0;
      width_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      act_q   <= act;
      tcnt_q  <= tcnt_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
      width_q <= width_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_measure.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pulse_measure: self-checking bench for pulse_measure (two instances). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pulse_measure;

  localparam int W0 = 16;
  localparam int S0 = 2;
  localparam int W8 = 8;
  localparam int S8 = 2;
`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  localparam int FILT = 2;
`else
  localparam int FILT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse = 1'b0, arm = 1'b0, ack = 1'b0;
  logic pulse8 = 1'b1, arm8 = 1'b0, ack8 = 1'b0;
  logic [W0-1:0] st0, wd0;
  logic [W8-1:0] st8, wd8;
  logic v0, b0, o0, v8, b8, o8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_measure #(.CNT_W(W0), .SYNC_STAGES(S0), .PULSE_TYPE(1)) dut (
    .CLK(clk), .RESETN(rst_n), .PULSE(pulse), .ARM(arm), .ACK(ack),
    .START_TIME(st0), .WIDTH(wd0), .VALID(v0), .BUSY(b0), .OVERFLOW(o0)
  );

  pulse_measure #(.CNT_W(W8), .SYNC_STAGES(S8), .PULSE_TYPE(0)) dut8 (
    .CLK(clk), .RESETN(rst_n), .PULSE(pulse8), .ARM(arm8), .ACK(ack8),
    .START_TIME(st8), .WIDTH(wd8), .VALID(v8), .BUSY(b8), .OVERFLOW(o8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pulse(input int which, input bit active);
    if (which == 0) pulse = active;
    else            pulse8 = ~active;
  endtask

  task automatic pulse_arm(input int which);
    if (which == 0) arm = 1'b1; else arm8 = 1'b1;
    tick();
    arm = 1'b0; arm8 = 1'b0;
  endtask

  task automatic pulse_ack(input int which);
    if (which == 0) ack = 1'b1; else ack8 = 1'b1;
    tick();
    ack = 1'b0; ack8 = 1'b0;
  endtask

  task automatic sample(input int which, output int v, output int st, output int wd,
                        output int ov, output int bz);
    if (which == 0) begin
      v = int'(v0); st = int'(st0); wd = int'(wd0); ov = int'(o0); bz = int'(b0);
    end else begin
      v = int'(v8); st = int'(st8); wd = int'(wd8); ov = int'(o8); bz = int'(b8);
    end
  endtask

  // ARM is sampled at edge 0; edge d is the first to see PULSE active, for n edges.
  task automatic do_measure(input int which, input int d, input int n);
    pulse_arm(which);
    repeat (d - 1) tick();
    set_pulse(which, 1'b1);
    repeat (n) tick();
    set_pulse(which, 1'b0);
  endtask

  task automatic wait_valid(input int which, input int budget, output bit ok);
    int v, st, wd, ov, bz;
    int cnt;
    cnt = 0;
    sample(which, v, st, wd, ov, bz);
    while (v == 0 && cnt < budget) begin
      tick();
      sample(which, v, st, wd, ov, bz);
      cnt++;
    end
    ok = (v == 1);
  endtask

  // Reference: start = D + sync depth (+ filter delay), saturating at all-ones.
  function automatic void model(input int which, input int d, input int n,
                                output int st, output int wd, output int ov);
    int maxv;
    int s;
    maxv = (which == 0) ? (1 << W0) - 1 : (1 << W8) - 1;
    s    = (which == 0) ? S0 : S8;
    st   = d + s + FILT;
    if (st > maxv) begin
      st = maxv; wd = maxv; ov = 1;
    end else if (n >= maxv) begin
      wd = maxv; ov = 1;
    end else begin
      wd = n; ov = 0;
    end
  endfunction

  task automatic test_reset();
    int v, st, wd, ov, bz;
    repeat (3) tick();
    sample(0, v, st, wd, ov, bz);
    checks++; if (v !== 0)  begin errors++; $display("FAIL reset_valid: got %0d expected 0", v); end
    checks++; if (bz !== 0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", bz); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", ov); end
    checks++; if (st !== 0) begin errors++; $display("FAIL reset_start: got %0d expected 0", st); end
    checks++; if (wd !== 0) begin errors++; $display("FAIL reset_width: got %0d expected 0", wd); end
    sample(1, v, st, wd, ov, bz);
    checks++; if (v !== 0 || bz !== 0) begin errors++; $display("FAIL reset_dut8: got valid %0d busy %0d expected 0 0", v, bz); end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    int v, st, wd, ov, bz;
    bit ok;
    do_measure(0, 500, 500);
    wait_valid(0, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no VALID expected VALID"); end
    sample(0, v, st, wd, ov, bz);
    checks++; if (st !== 502 + FILT) begin errors++; $display("FAIL basic_start: got %0d expected %0d", st, 502 + FILT); end
    checks++; if (wd !== 500) begin errors++; $display("FAIL basic_width: got %0d expected 500", wd); end
    checks++; if (ov !== 0 || bz !== 0) begin errors++; $display("FAIL basic_flags: got ovf %0d busy %0d expected 0 0", ov, bz); end
    pulse_ack(0);
    sample(0, v, st, wd, ov, bz);
    checks++; if (v !== 0) begin errors++; $display("FAIL basic_ack: got valid %0d expected 0", v); end
    repeat (6) tick();
  endtask

  task automatic test_active_low();
    int v, st, wd, ov, bz;
    bit ok;
    do_measure(1, 20, 10);
    wait_valid(1, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL low_timeout: got no VALID expected VALID"); end
    sample(1, v, st, wd, ov, bz);
    checks++; if (st !== 22 + FILT) begin errors++; $display("FAIL low_start: got %0d expected %0d", st, 22 + FILT); end
    checks++; if (wd !== 10) begin errors++; $display("FAIL low_width: got %0d expected 10", wd); end
    pulse_ack(1);
    repeat (6) tick();
  endtask

  task automatic test_preactive();
    int v, st, wd, ov, bz;
    bit ok;
    set_pulse(0, 1'b1);
    repeat (8) tick();
    pulse_arm(0);
    repeat (4) tick();
    set_pulse(0, 1'b0);
    repeat (25) tick();
    set_pulse(0, 1'b1);
    repeat (7) tick();
    set_pulse(0, 1'b0);
    wait_valid(0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pre_timeout: got no VALID expected VALID"); end
    sample(0, v, st, wd, ov, bz);
    checks++; if (st !== 32 + FILT) begin errors++; $display("FAIL pre_start: got %0d expected %0d", st, 32 + FILT); end
    checks++; if (wd !== 7) begin errors++; $display("FAIL pre_width: got %0d expected 7", wd); end
    pulse_ack(0);
    repeat (6) tick();
  endtask

`ifndef PULSE_MEASURE_GLITCH_FILTER_EN
  task automatic test_min_pulse();
    int v, st, wd, ov, bz;
    bit ok;
    do_measure(0, 10, 1);
    wait_valid(0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL min_timeout: got no VALID expected VALID"); end
    sample(0, v, st, wd, ov, bz);
    checks++; if (st !== 12 || wd !== 1) begin errors++; $display("FAIL min_pulse: got start %0d width %0d expected 12 1", st, wd); end
    pulse_ack(0);
    repeat (6) tick();
  endtask
`else
  task automatic test_glitch_filter();
    int v, st, wd, ov, bz;
    bit ok;
    pulse_arm(0);
    repeat (9) tick();
    set_pulse(0, 1'b1);
    repeat (2) tick();
    set_pulse(0, 1'b0);
    repeat (488) tick();
    set_pulse(0, 1'b1);
    repeat (500) tick();
    set_pulse(0, 1'b0);
    wait_valid(0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL glitch_timeout: got no VALID expected VALID"); end
    sample(0, v, st, wd, ov, bz);
    checks++; if (st !== 504 || wd !== 500) begin errors++; $display("FAIL glitch: got start %0d width %0d expected 504 500", st, wd); end
    pulse_ack(0);
    repeat (6) tick();
  endtask
`endif

  task automatic test_time_overflow();
    int v, st, wd, ov, bz;
    pulse_arm(1);
    repeat (254) tick();
    sample(1, v, st, wd, ov, bz);
    checks++; if (v !== 0 || bz !== 1) begin errors++; $display("FAIL tovf_early: got valid %0d busy %0d expected 0 1", v, bz); end
    tick();
    sample(1, v, st, wd, ov, bz);
    checks++; if (v !== 1 || ov !== 1) begin errors++; $display("FAIL tovf_flags: got valid %0d ovf %0d expected 1 1", v, ov); end
    checks++; if (st !== 255 || wd !== 255) begin errors++; $display("FAIL tovf_fields: got start %0d width %0d expected 255 255", st, wd); end
    pulse_ack(1);
    sample(1, v, st, wd, ov, bz);
    checks++; if (v !== 0 || ov !== 0) begin errors++; $display("FAIL tovf_ack: got valid %0d ovf %0d expected 0 0", v, ov); end
    repeat (6) tick();
  endtask

  task automatic test_width_overflow();
    int v, st, wd, ov, bz;
    bit ok;
    do_measure(1, 5, 300);
    wait_valid(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wovf_timeout: got no VALID expected VALID"); end
    sample(1, v, st, wd, ov, bz);
    checks++; if (st !== 7 + FILT || wd !== 255 || ov !== 1) begin
      errors++; $display("FAIL wovf: got start %0d width %0d ovf %0d expected %0d 255 1", st, wd, ov, 7 + FILT);
    end
    pulse_ack(1);
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int v, st, wd, ov, bz;
    bit ok;
    pulse_arm(0);
    repeat (9) tick();
    set_pulse(0, 1'b1);
    repeat (10) tick();
    sample(0, v, st, wd, ov, bz);
    checks++; if (bz !== 1 || st !== 12 + FILT) begin errors++; $display("FAIL rmid_pre: got busy %0d start %0d expected 1 %0d", bz, st, 12 + FILT); end
    rst_n = 1'b0;
    #1;
    sample(0, v, st, wd, ov, bz);
    checks++; if (v !== 0 || bz !== 0 || ov !== 0 || st !== 0 || wd !== 0) begin
      errors++; $display("FAIL rmid_async: got v %0d b %0d o %0d s %0d w %0d expected all 0", v, bz, ov, st, wd);
    end
    set_pulse(0, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    sample(0, v, st, wd, ov, bz);
    checks++; if (v !== 0 || bz !== 0) begin errors++; $display("FAIL rmid_release: got valid %0d busy %0d expected 0 0", v, bz); end
    do_measure(0, 37, 21);
    wait_valid(0, 100, ok);
    sample(0, v, st, wd, ov, bz);
    checks++; if (!ok || st !== 39 + FILT || wd !== 21) begin
      errors++; $display("FAIL rmid_fresh: got valid %0d start %0d width %0d expected 1 %0d 21", v, st, wd, 39 + FILT);
    end
    pulse_ack(0);
    repeat (6) tick();
  endtask

  task automatic test_arm_ack_rules();
    int v, st, wd, ov, bz;
    bit ok;
    pulse_ack(0);
    sample(0, v, st, wd, ov, bz);
    checks++; if (v !== 0 || bz !== 0) begin errors++; $display("FAIL idle_ack: got valid %0d busy %0d expected 0 0", v, bz); end
    pulse_arm(0);
    repeat (3) tick();
    pulse_arm(0);
    pulse_ack(0);
    repeat (34) tick();
    set_pulse(0, 1'b1);
    repeat (15) tick();
    set_pulse(0, 1'b0);
    wait_valid(0, 100, ok);
    sample(0, v, st, wd, ov, bz);
    checks++; if (!ok || st !== 42 + FILT || wd !== 15) begin
      errors++; $display("FAIL rearm_ignored: got valid %0d start %0d width %0d expected 1 %0d 15", v, st, wd, 42 + FILT);
    end
    arm = 1'b1; ack = 1'b1;
    tick();
    arm = 1'b0; ack = 1'b0;
    repeat (3) tick();
    sample(0, v, st, wd, ov, bz);
    checks++; if (v !== 0 || bz !== 0) begin errors++; $display("FAIL arm_ack_same: got valid %0d busy %0d expected 0 0", v, bz); end
    repeat (4) tick();
  endtask

  task automatic test_random();
    int v, st, wd, ov, bz;
    int d, n, which, est, ewd, eov;
    bit ok;
    for (int it = 0; it < 12; it++) begin
      which = it % 2;
      d = (which == 0) ? int'($urandom_range(1, 400)) : int'($urandom_range(1, 270));
      n = int'($urandom_range(3, 300));
      model(which, d, n, est, ewd, eov);
      do_measure(which, d, n);
      wait_valid(which, 2000, ok);
      sample(which, v, st, wd, ov, bz);
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout: got no VALID expected VALID (d=%0d n=%0d)", it, d, n); end
      checks++; if (st !== est || wd !== ewd || ov !== eov) begin
        errors++;
        $display("FAIL rnd%0d (dut%0d d=%0d n=%0d): got start %0d width %0d ovf %0d expected %0d %0d %0d",
                 it, which, d, n, st, wd, ov, est, ewd, eov);
      end
      pulse_ack(which);
      sample(which, v, st, wd, ov, bz);
      checks++; if (v !== 0 || ov !== 0) begin errors++; $display("FAIL rnd%0d_ack: got valid %0d ovf %0d expected 0 0", it, v, ov); end
      repeat (6) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_active_low();
    test_preactive();
`ifndef PULSE_MEASURE_GLITCH_FILTER_EN
    test_min_pulse();
`else
    test_glitch_filter();
`endif
    test_time_overflow();
    test_width_overflow();
    test_reset_mid();
    test_arm_ack_rules();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
